// File: rtl/sensor_poll_sequencer.sv
// Sensor poll sequencer: on each rising edge of the 10 Hz divider output,
// advances mission time and polls every sensor over REQ/ACK with a timeout.
//
// Ports:
//   CLK_1MHZ_IN   in   system clock, rising edge
//   RESET         in   asynchronous active-high reset
//   CLK_10HZ_IN   in   10 Hz divider output, same clock domain
//   SENSOR_ACK    in   per-sensor acknowledge (selected bit only)
//   SENSOR_REQ    out  registered one-hot-or-zero poll request
//   SEQ_BUSY      out  high whenever the sequencer is not idle
//   FRAME_DONE    out  one-cycle pulse at the end of each frame
//   TIMEOUT_MASK  out  sensors that timed out in the last frame
//   OVERRUN       out  sticky: tick arrived while busy
//   MISSION_TIME  out  10 Hz tick count since reset
//   FRAME_COUNT   out  completed frame count
module sensor_poll_sequencer #(
    parameter int NUM_SENSORS    = 4,
    parameter int TIMEOUT_CYCLES = 1000
) (
    input  logic                   CLK_1MHZ_IN,
    input  logic                   RESET,
    input  logic                   CLK_10HZ_IN,
    input  logic [NUM_SENSORS-1:0] SENSOR_ACK,
    output logic [NUM_SENSORS-1:0] SENSOR_REQ,
    output logic                   SEQ_BUSY,
    output logic                   FRAME_DONE,
    output logic [NUM_SENSORS-1:0] TIMEOUT_MASK,
    output logic                   OVERRUN,
    output logic [31:0]            MISSION_TIME,
    output logic [15:0]            FRAME_COUNT
);

    localparam int IW = (NUM_SENSORS > 1) ? $clog2(NUM_SENSORS) : 1;
    localparam logic [IW-1:0] LAST  = IW'(NUM_SENSORS - 1);
    localparam logic [15:0]   TLAST = 16'(TIMEOUT_CYCLES - 1);
    localparam logic [NUM_SENSORS-1:0] ONE = NUM_SENSORS'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        GAP  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t                 state, state_n;
    logic [IW-1:0]          idx, idx_n;
    logic [15:0]            timer, timer_n;
    logic [NUM_SENSORS-1:0] wmask, wmask_n;
    logic [NUM_SENSORS-1:0] mask_n;
    logic [NUM_SENSORS-1:0] req_n;
    logic [31:0]            mtime_n;
    logic [15:0]            fcount_n;
    logic                   overrun_n;
    logic                   clk10_d;
    logic                   tick;
    logic                   leave;

    always_ff @(posedge CLK_1MHZ_IN or posedge RESET) begin
        if (RESET) begin
            state        <= IDLE;
            idx          <= '0;
            timer        <= '0;
            wmask        <= '0;
            clk10_d      <= 1'b1;
            SENSOR_REQ   <= '0;
            TIMEOUT_MASK <= '0;
            OVERRUN      <= 1'b0;
            MISSION_TIME <= '0;
            FRAME_COUNT  <= '0;
        end else begin
            state        <= state_n;
            idx          <= idx_n;
            timer        <= timer_n;
            wmask        <= wmask_n;
            clk10_d      <= CLK_10HZ_IN;
            SENSOR_REQ   <= req_n;
            TIMEOUT_MASK <= mask_n;
            OVERRUN      <= overrun_n;
            MISSION_TIME <= mtime_n;
            FRAME_COUNT  <= fcount_n;
        end
    end

    always_comb begin
        tick      = CLK_10HZ_IN & ~clk10_d;
        state_n   = state;
        idx_n     = idx;
        timer_n   = timer;
        wmask_n   = wmask;
        mask_n    = TIMEOUT_MASK;
        fcount_n  = FRAME_COUNT;
        mtime_n   = MISSION_TIME + 32'(tick);
        // A tick during a frame is dropped; the frame runs on.
        overrun_n = OVERRUN | (tick & (state != IDLE));
        leave     = 1'b0;

        unique case (state)
            IDLE: begin
                if (tick) begin
                    state_n = REQ;
                    idx_n   = '0;
                    timer_n = '0;
                    wmask_n = '0;
                end
            end
            REQ: begin
                // Ack beats a timeout landing on the same edge.
                if (SENSOR_ACK[idx]) begin
                    leave = 1'b1;
                end else if (timer == TLAST) begin
                    wmask_n[idx] = 1'b1;
                    leave        = 1'b1;
                end else begin
                    timer_n = timer + 16'd1;
                end
                if (leave) begin
                    state_n = (idx == LAST) ? DONE : GAP;
                end
            end
            GAP: begin
                idx_n   = idx + IW'(1);
                timer_n = '0;
                state_n = REQ;
            end
            DONE: begin
                mask_n   = wmask;
                fcount_n = FRAME_COUNT + 16'd1;
                state_n  = IDLE;
            end
            default: state_n = IDLE;
        endcase

        // Request is registered from the next state so it
        // lines up with the state it belongs to.
        req_n = (state_n == REQ) ? (ONE << idx_n) : '0;
    end

    assign SEQ_BUSY   = (state != IDLE);
    assign FRAME_DONE = (state == DONE);

endmodule

// File: tb/tb_sensor_poll_sequencer.sv
// Directed bench for sensor_poll_sequencer (4 sensors, 1000-cycle timeout).
// Vector table for the all-ack frame plus hand-written corner sequences.
module tb_sensor_poll_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        clk10;
    logic [3:0]  ack;
    logic [3:0]  req;
    logic        busy;
    logic        done;
    logic [3:0]  tmask;
    logic        ovr;
    logic [31:0] mtime;
    logic [15:0] fcount;

    int errors = 0;
    int checks = 0;
    int req_cnt[4];
    int done_cnt;

    sensor_poll_sequencer #(
        .NUM_SENSORS(4),
        .TIMEOUT_CYCLES(1000)
    ) dut (
        .CLK_1MHZ_IN (clk),
        .RESET       (rst),
        .CLK_10HZ_IN (clk10),
        .SENSOR_ACK  (ack),
        .SENSOR_REQ  (req),
        .SEQ_BUSY    (busy),
        .FRAME_DONE  (done),
        .TIMEOUT_MASK(tmask),
        .OVERRUN     (ovr),
        .MISSION_TIME(mtime),
        .FRAME_COUNT (fcount)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] req;
        logic       done;
        logic       busy;
    } vec_t;

    vec_t tbl[10];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        clk10 = 1'b0;
        step();
    endtask

    // Steps until FRAME_DONE, counting REQ cycles per sensor,
    // then two more cycles so end-of-frame registers settle.
    task automatic run_to_done(input int budget);
        bit seen = 0;
        for (int j = 0; j < 4; j++) req_cnt[j] = 0;
        done_cnt = 0;
        for (int i = 0; i < budget && !seen; i++) begin
            step();
            for (int j = 0; j < 4; j++)
                if (req[j]) req_cnt[j]++;
            if (done) begin
                done_cnt++;
                seen = 1;
            end
        end
        chk("frame_done_seen", 32'(seen), 32'd1);
        step();
        step();
    endtask

    initial begin
        tbl[0] = '{4'b0001, 1'b0, 1'b1};
        tbl[1] = '{4'b0000, 1'b0, 1'b1};
        tbl[2] = '{4'b0010, 1'b0, 1'b1};
        tbl[3] = '{4'b0000, 1'b0, 1'b1};
        tbl[4] = '{4'b0100, 1'b0, 1'b1};
        tbl[5] = '{4'b0000, 1'b0, 1'b1};
        tbl[6] = '{4'b1000, 1'b0, 1'b1};
        tbl[7] = '{4'b0000, 1'b1, 1'b1};
        tbl[8] = '{4'b0000, 1'b0, 1'b0};
        tbl[9] = '{4'b0000, 1'b0, 1'b0};

        // Reset with the 10 Hz input already high: no tick.
        rst = 1'b1;
        clk10 = 1'b1;
        ack = 4'b0000;
        step();
        step();
        rst = 1'b0;
        step();
        step();
        chk("rst_req", 32'(req), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_mask", 32'(tmask), 32'd0);
        chk("rst_ovr", 32'(ovr), 32'd0);
        chk("rst_mtime", mtime, 32'd0);
        chk("rst_fcount", 32'(fcount), 32'd0);
        clk10 = 1'b0;
        step();
        chk("no_tick_mtime", mtime, 32'd0);

        // All acks high: table-driven frame timing.
        ack = 4'b1111;
        clk10 = 1'b1;
        for (int k = 0; k < 10; k++) begin
            step();
            chk($sformatf("tbl%0d_req", k + 1), 32'(req),
                32'(tbl[k].req));
            chk($sformatf("tbl%0d_done", k + 1), 32'(done),
                32'(tbl[k].done));
            chk($sformatf("tbl%0d_busy", k + 1), 32'(busy),
                32'(tbl[k].busy));
        end
        chk("f1_mask", 32'(tmask), 32'd0);
        chk("f1_fcount", 32'(fcount), 32'd1);
        chk("f1_mtime", mtime, 32'd1);
        clk10 = 1'b0;
        step();

        // Sensor 2 silent: times out after exactly 1000 cycles.
        ack = 4'b1011;
        clk10 = 1'b1;
        run_to_done(3000);
        chk("to_req2_cycles", 32'(req_cnt[2]), 32'd1000);
        chk("to_req0_cycles", 32'(req_cnt[0]), 32'd1);
        chk("to_mask", 32'(tmask), 32'b0100);
        chk("to_fcount", 32'(fcount), 32'd2);
        clk10 = 1'b0;
        step();

        // Same frame with sensor 2 answering clears the mask.
        ack = 4'b1111;
        clk10 = 1'b1;
        run_to_done(100);
        chk("fix_req2_cycles", 32'(req_cnt[2]), 32'd1);
        chk("fix_mask", 32'(tmask), 32'd0);
        chk("fix_fcount", 32'(fcount), 32'd3);
        chk("fix_mtime", mtime, 32'd3);
        chk("fix_ovr", 32'(ovr), 32'd0);

        // Two ticks six cycles apart, no acks: overrun.
        do_reset();
        ack = 4'b0000;
        clk10 = 1'b1;
        step();
        chk("ovr_before", 32'(ovr), 32'd0);
        clk10 = 1'b0;
        for (int i = 0; i < 5; i++) step();
        clk10 = 1'b1;
        step();
        chk("ovr_set", 32'(ovr), 32'd1);
        chk("ovr_mtime", mtime, 32'd2);
        run_to_done(6000);
        for (int i = 0; i < 20; i++) begin
            step();
            if (done) done_cnt++;
        end
        chk("ovr_frames", 32'(done_cnt), 32'd1);
        chk("ovr_fcount", 32'(fcount), 32'd1);
        chk("ovr_mask", 32'(tmask), 32'b1111);
        chk("ovr_sticky", 32'(ovr), 32'd1);
        chk("ovr_req3_cycles", 32'(req_cnt[3]), 32'd1000);

        // Ack on the timeout edge wins; stray ACK[3] during REQ[0].
        do_reset();
        begin
            int n0 = 0;
            ack = 4'b0110;
            clk10 = 1'b1;
            for (int i = 0; i < 3000 && !done; i++) begin
                step();
                if (req[0]) n0++;
                if (n0 == 10) begin
                    ack = 4'b1110;
                end else if (n0 == 11 && req[0]) begin
                    chk("stray_ack_req", 32'(req), 32'b0001);
                    ack = 4'b0110;
                end else if (n0 == 1000) begin
                    ack = 4'b1111;
                end
            end
            chk("edge_done_seen", 32'(done), 32'd1);
            chk("edge_req0_cycles", 32'(n0), 32'd1000);
            step();
            step();
            chk("edge_mask", 32'(tmask), 32'd0);
            chk("edge_fcount", 32'(fcount), 32'd1);
        end

        // Reset while REQ[1] is high.
        do_reset();
        begin
            bit found = 0;
            ack = 4'b1111;
            clk10 = 1'b1;
            for (int i = 0; i < 20 && !found; i++) begin
                step();
                if (req == 4'b0010) found = 1;
            end
            chk("mid_req1_seen", 32'(found), 32'd1);
            rst = 1'b1;
            #1;
            chk("mid_async_req", 32'(req), 32'd0);
            chk("mid_async_busy", 32'(busy), 32'd0);
            step();
            step();
            rst = 1'b0;
            done_cnt = 0;
            for (int i = 0; i < 12; i++) begin
                step();
                if (done) done_cnt++;
            end
            chk("mid_no_done", 32'(done_cnt), 32'd0);
            chk("mid_busy", 32'(busy), 32'd0);
            chk("mid_fcount", 32'(fcount), 32'd0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
